sysctrl_rst: RTL and testbench
==============================

// Module: sysctrl_rst
// PURPOSE
//  Parametrised system control register. Generates a timed system-reset pulse from a
//  software request or from NCAUSE hardware sources (watchdog, stack monitor, ...).
//  Records the last reset cause and a saturating reset count. Holds software scratch
//  bits that survive system resets. Sits on the IO bus next to the CPU; sysrst drives
//  the system reset tree, rst_n is the board/power-on reset.
// PARAMETERS
//  DW            32  register width; legal range 16..32
//  NCAUSE        4   hardware reset-request inputs; legal range 1..14
//  RST_CYCLES    16  sysrst pulse length in clk cycles; minimum 1
//  SETTLE_CYCLES 4   quiet cycles after the pulse, during which new requests are ignored; minimum 0
// PORTS
//  clk       in   1       system clock
//  rst_n     in   1       synchronous reset, active low
//  wr        in   1       register write strobe, one cycle
//  data_in   in   DW      write data
//  data_out  out  DW      register read value (combinational from state)
//  cause_in  in   NCAUSE  hardware reset requests, level-sampled each clk
//  sysrst    out  1       system reset pulse, active high
//  rst_busy  out  1       high during PULSE and SETTLE
// BEHAVIOUR
//  Single clock. Reset is synchronous and active-low on rst_n.
//  Register layout:
//   [0]       read: sysrst; write 1: software reset request
//   [3:1]     scratch, R/W
//   [7:4]     cause, RO: 0 = rst_n, 1 = software, 2+i = cause_in[i]
//   [15:8]    reset count, RO, saturates at 255
//   [DW-1:16] scratch, R/W; this field is absent when DW = 16
//  Reset (rst_n = 0 at a clk edge):
//   - state IDLE; sysrst = 0; rst_busy = 0
//   - cause = 0; count = 0; all scratch bits = 0
//   - rst_n overrides any request in the same cycle
//  Pulse counter: $clog2(RST_CYCLES + SETTLE_CYCLES + 1) bits wide.
//  FSM states: IDLE, PULSE, SETTLE.
//   IDLE -> PULSE on a request sampled at edge N.
//    - request = any cause_in bit, or (wr & data_in[0])
//    - cause and count update at edge N
//    - sysrst = 1 from edge N for exactly RST_CYCLES cycles
//   PULSE -> SETTLE after RST_CYCLES cycles; sysrst = 0.
//    - if SETTLE_CYCLES = 0, go PULSE -> IDLE directly
//   SETTLE -> IDLE after SETTLE_CYCLES cycles.
//   In PULSE and SETTLE:
//    - requests are ignored, not queued
//    - a cause_in still high on return to IDLE triggers a new pulse
//  Priority among simultaneous requests: cause_in[0] > ... > cause_in[NCAUSE-1] > software.
//   - the lowest set index is recorded as the cause
//  Writes:
//   - scratch fields update on any wr, in every state, including the cycle that triggers
//   - writes to bits [15:4] have no effect
//   - data_in[0] = 1 outside IDLE has no effect
//  Scratch, cause and count are NOT cleared by sysrst; only rst_n clears them.
//  Count increments once per accepted request and holds at 255.
//  data_out = {scratch_hi, count, cause, scratch_lo, sysrst}.
// TESTING
//  T1 rst_n low 2 cycles, then high -> data_out = 0, sysrst = 0, rst_busy = 0.
//  T2 wr, data_in = 32'hABCD_000F (defaults) ->
//     - sysrst high exactly 16 cycles, then busy 4 more cycles
//     - data_out[31:16] = ABCD, [3:1] = 7, cause = 1, count = 1
//  T3 cause_in = 4'b1010 for one cycle in IDLE -> cause = 3 (index 1), count increments.
//  T4 software request during PULSE, and cause_in[2] pulse during SETTLE ->
//     no second pulse, count unchanged.
//  T5 cause_in[0] held high continuously ->
//     - back-to-back pulses separated by 4 quiet cycles
//     - count saturates at 255 after 255 pulses
//  T6 rst_n low mid-PULSE -> sysrst = 0 next cycle; count, cause and scratch = 0; state IDLE.

Source files
------------

// File: rtl/sysctrl_rst.sv
// System control register: timed system-reset pulse generator with reset-cause
// recording, a saturating reset counter and scratch bits that survive sysrst.
module sysctrl_rst #(
  parameter int unsigned DW            = 32,
  parameter int unsigned NCAUSE        = 4,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DW-1:0]     data_in,
  output logic [DW-1:0]     data_out,
  input  logic [NCAUSE-1:0] cause_in,
  output logic              sysrst,
  output logic              rst_busy
);

  localparam int unsigned CW       = $clog2(RST_CYCLES + SETTLE_CYCLES + 1);
  localparam int unsigned CAUSE_W  = 4;
  localparam int unsigned COUNT_W  = 8;
  localparam int unsigned SCR_LO_W = 3;

  localparam logic [CW-1:0] PULSE_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  localparam logic [CAUSE_W-1:0] CAUSE_SW  = CAUSE_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  accept_c;
  logic                  req_c;
  logic [CAUSE_W-1:0]    new_cause_c;
  logic [CAUSE_W-1:0]    cause_q;
  logic [COUNT_W-1:0]    count_q;
  logic [SCR_LO_W-1:0]   scratch_lo;
  logic                  unused_bits;

  // Read-only field bits of the write data are intentionally discarded.
  assign unused_bits = ^data_in[15:4];

  // Any hardware source or a software write of bit 0 requests a reset.
  assign req_c = (|cause_in) | (wr & data_in[0]);

  // Lowest set cause_in index wins; software only when no hardware source is set.
  always_comb begin
    new_cause_c = CAUSE_SW;
    for (int i = int'(NCAUSE) - 1; i >= 0; i--) begin
      if (cause_in[i]) new_cause_c = CAUSE_W'(i + 2);
    end
  end

  // Next-state and pulse/settle counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          state_d  = PULSE;
          cnt_d    = '0;
          accept_c = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, registered outputs, cause/count capture and low scratch bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sysrst     <= 1'b0;
      rst_busy   <= 1'b0;
      cause_q    <= '0;
      count_q    <= '0;
      scratch_lo <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sysrst   <= (state_d == PULSE);
      rst_busy <= (state_d != IDLE);
      if (accept_c) begin
        cause_q <= new_cause_c;
        if (count_q != COUNT_MAX) count_q <= count_q + COUNT_W'(1);
      end
      if (wr) scratch_lo <= data_in[3:1];
    end
  end

  if (DW > 16) begin : g_scratch_hi
    logic [DW-17:0] scratch_hi;

    // Upper scratch field, written on any wr.
    always_ff @(posedge clk) begin
      if (!rst_n)  scratch_hi <= '0;
      else if (wr) scratch_hi <= data_in[DW-1:16];
    end

    assign data_out = {scratch_hi, count_q, cause_q, scratch_lo, sysrst};
  end else begin : g_no_scratch_hi
    assign data_out = {count_q, cause_q, scratch_lo, sysrst};
  end

endmodule

// File: tb/tb_sysctrl_rst.sv
// Directed bench for sysctrl_rst with default parameters.
module tb_sysctrl_rst;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  cause_in;
  logic        sysrst;
  logic        rst_busy;

  int checks;
  int failures;

  sysctrl_rst #(
    .DW(32), .NCAUSE(4), .RST_CYCLES(16), .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .data_out(data_out),
    .cause_in(cause_in), .sysrst(sysrst), .rst_busy(rst_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b0; data_in = '0; cause_in = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (data_out !== 32'h0) begin
      failures++; $display("FAIL reset_data_out got=%h exp=%h", data_out, 32'h0);
    end
    checks++;
    if (sysrst !== 1'b0 || rst_busy !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got sysrst=%b busy=%b exp 0 0", sysrst, rst_busy);
    end
  endtask

  task automatic test_sw_pulse();
    int hi;
    int st;
    wr = 1'b1; data_in = 32'hABCD_000F;
    tick();
    wr = 1'b0; data_in = '0;
    checks++;
    if (data_out !== 32'hABCD_011F) begin
      failures++; $display("FAIL sw_pulse_start got=%h exp=%h", data_out, 32'hABCD_011F);
    end
    hi = 0;
    for (int i = 0; i < 100 && sysrst; i++) begin
      hi++;
      tick();
    end
    checks++;
    if (hi != 16) begin
      failures++; $display("FAIL sw_pulse_len got=%0d exp=16", hi);
    end
    st = 0;
    for (int i = 0; i < 100 && rst_busy; i++) begin
      st++;
      tick();
    end
    checks++;
    if (st != 4) begin
      failures++; $display("FAIL sw_settle_len got=%0d exp=4", st);
    end
    checks++;
    if (data_out !== 32'hABCD_011E || rst_busy !== 1'b0) begin
      failures++; $display("FAIL sw_after got=%h busy=%b exp=%h busy=0", data_out, rst_busy, 32'hABCD_011E);
    end
  endtask

  task automatic test_cause_priority();
    cause_in = 4'b1010;
    tick();
    cause_in = '0;
    checks++;
    if (data_out !== 32'hABCD_023F) begin
      failures++; $display("FAIL cause_priority got=%h exp=%h", data_out, 32'hABCD_023F);
    end
    for (int i = 0; i < 100 && rst_busy; i++) tick();
    checks++;
    if (rst_busy !== 1'b0) begin
      failures++; $display("FAIL cause_idle_timeout busy=%b exp=0", rst_busy);
    end
  endtask

  task automatic test_ignored_requests();
    int extra;
    wr = 1'b1; data_in = 32'hABCD_000F;
    tick();
    wr = 1'b0; data_in = '0;
    tick(); tick(); tick();
    // Scratch updates mid-pulse; bit 0 and bits [15:4] have no effect.
    wr = 1'b1; data_in = 32'h1234_FFF5;
    tick();
    wr = 1'b0; data_in = '0;
    checks++;
    if (data_out !== 32'h1234_0315) begin
      failures++; $display("FAIL ignore_sw_in_pulse got=%h exp=%h", data_out, 32'h1234_0315);
    end
    for (int i = 0; i < 100 && sysrst; i++) tick();
    checks++;
    if (sysrst !== 1'b0 || rst_busy !== 1'b1) begin
      failures++; $display("FAIL ignore_enter_settle got sysrst=%b busy=%b exp 0 1", sysrst, rst_busy);
    end
    cause_in = 4'b0100;
    tick();
    cause_in = '0;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      if (sysrst) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      failures++; $display("FAIL ignore_no_second_pulse got=%0d high cycles exp=0", extra);
    end
    checks++;
    if (data_out !== 32'h1234_0314) begin
      failures++; $display("FAIL ignore_regs got=%h exp=%h", data_out, 32'h1234_0314);
    end
  endtask

  task automatic test_reset_mid_pulse();
    cause_in = 4'b1000;
    tick();
    cause_in = '0;
    checks++;
    if (data_out !== 32'h1234_0455) begin
      failures++; $display("FAIL mid_start got=%h exp=%h", data_out, 32'h1234_0455);
    end
    tick(); tick(); tick(); tick(); tick();
    rst_n = 1'b0; cause_in = 4'b0001; wr = 1'b1; data_in = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (sysrst !== 1'b0 || rst_busy !== 1'b0 || data_out !== 32'h0) begin
      failures++; $display("FAIL mid_reset got sysrst=%b busy=%b data=%h exp 0 0 0", sysrst, rst_busy, data_out);
    end
    rst_n = 1'b1; cause_in = '0; wr = 1'b0; data_in = '0;
    tick();
    checks++;
    if (sysrst !== 1'b0 || rst_busy !== 1'b0 || data_out !== 32'h0) begin
      failures++; $display("FAIL mid_after got sysrst=%b busy=%b data=%h exp 0 0 0", sysrst, rst_busy, data_out);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int hi;
    int lo;
    int idl;
    int exp_cnt;
    logic prev;
    prev = sysrst; k = 0; hi = 0; lo = 0; idl = 0;
    cause_in = 4'b0001;
    for (int cyc = 0; cyc < 7000 && k < 256; cyc++) begin
      tick();
      if (sysrst && !prev) begin
        k++;
        if (k >= 2 && k <= 3) begin
          checks++;
          if (lo != 5 || idl != 1) begin
            failures++; $display("FAIL b2b_gap pulse=%0d got low=%0d idle=%0d exp low=5 idle=1", k, lo, idl);
          end
        end
        if (k == 1 || k == 2 || k == 254 || k == 255 || k == 256) begin
          exp_cnt = (k > 255) ? 255 : k;
          checks++;
          if (data_out[15:4] !== {8'(exp_cnt), 4'd2}) begin
            failures++; $display("FAIL b2b_count pulse=%0d got=%h exp=%h", k, data_out[15:4], {8'(exp_cnt), 4'd2});
          end
        end
        hi = 0; lo = 0; idl = 0;
      end
      if (!sysrst && prev && k <= 3) begin
        checks++;
        if (hi != 16) begin
          failures++; $display("FAIL b2b_len pulse=%0d got=%0d exp=16", k, hi);
        end
      end
      if (sysrst) hi++;
      else lo++;
      if (!rst_busy) idl++;
      prev = sysrst;
    end
    checks++;
    if (k != 256) begin
      failures++; $display("FAIL b2b_timeout got=%0d pulses exp=256", k);
    end
    cause_in = '0;
    for (int i = 0; i < 100 && rst_busy; i++) tick();
    checks++;
    if (rst_busy !== 1'b0 || data_out[15:8] !== 8'd255) begin
      failures++; $display("FAIL b2b_final got busy=%b count=%0d exp busy=0 count=255", rst_busy, data_out[15:8]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sw_pulse();
    test_cause_priority();
    test_ignored_requests();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
